mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL take these parameters: NCH, 4, channel count (2..8); AW, 32, address width; DW, 8, data width.
REQ-002 The clock SHALL be `clk  input  1  clock`; all logic is sampled on its rising edge.
REQ-003 The reset SHALL be `reset  input  1  synchronous, active-high reset`.
REQ-004 The block SHALL have the port `ch_req  input  NCH  per-channel request valid, held until granted`.
REQ-005 The block SHALL have the port `ch_we  input  NCH  per-channel 1=write, 0=read`.
REQ-006 The block SHALL have the port `ch_addr  input  NCH*AW  per-channel address, channel i at [i*AW +: AW]`.
REQ-007 The block SHALL have the port `ch_wdata  input  NCH*DW  per-channel write data, same packing`.
REQ-008 The block SHALL have the port `ch_gnt  output  NCH  one-cycle grant pulse, one-hot`.
REQ-009 The block SHALL have the port `ch_rd_rdy  output  NCH  one-cycle read-data-valid pulse to the owning channel`.
REQ-010 The block SHALL have the port `ch_rdata  output  DW  read data, valid with ch_rd_rdy`.
REQ-011 The block SHALL have the ports `addr  output  AW`, `wr_req  output  1`, `rd_req  output  1` and `wdata  output  DW`, forming the memory-side request.
REQ-012 The block SHALL have the ports `rdata  input  DW`, `busy  input  1` and `rd_rdy  input  1`, forming the memory-side response.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT_WR, WAIT_RD.
REQ-014 IDLE: when any ch_req=1 and busy=0, the block SHALL pick winner w, latch ch_addr/ch_wdata/ch_we of w, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-015 ISSUE (one cycle): the block SHALL assert ch_gnt[w]=1 and exactly one of wr_req/rd_req=1, with addr and wdata driven from the latch.
REQ-016 After ISSUE, a write SHALL go to WAIT_WR and a read SHALL go to WAIT_RD.
REQ-017 WAIT_WR: the block SHALL return to IDLE on the first cycle with busy=0; the first cycle after ISSUE SHALL be ignored, giving a minimum dwell of 2 cycles.
REQ-018 WAIT_RD: on rd_rdy=1, the block SHALL register rdata into ch_rdata, pulse ch_rd_rdy[w]=1 in the next cycle, and enter IDLE in that same cycle.
REQ-019 Request latency SHALL be: ch_req sampled in IDLE at cycle N -> wr_req/rd_req and ch_gnt at cycle N+1.
REQ-020 Read-data latency SHALL be: rd_rdy at cycle M -> ch_rd_rdy at M+1.
REQ-021 Requests SHALL be sampled only in IDLE; a ch_req deasserted before grant is dropped silently.
REQ-022 wr_req, rd_req and ch_gnt SHALL be 0 in every state except ISSUE.
REQ-023 ch_rd_rdy SHALL be 0 except for the single cycle defined in REQ-018.
REQ-024 addr and wdata SHALL hold their last value outside ISSUE.
REQ-025 rd_rdy arriving in IDLE, ISSUE or WAIT_WR SHALL be ignored.
REQ-026 Only one transaction SHALL be outstanding at a time.

Reset
REQ-027 On reset=1 the block SHALL enter IDLE, set addr, wdata, ch_rdata, wr_req, rd_req, ch_gnt and ch_rd_rdy to 0, and set the priority pointer to 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no ch_rd_rdy pulse.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the pointer, and after each grant the pointer becomes (w+1) mod NCH.
REQ-031 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority, with the lowest index winning, and no pointer register SHALL exist.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the FSM state enum and the default constants for NCH, AW and DW.
REQ-033 Winner selection SHALL be a sub-module, mem_arb_pick: inputs req[NCH] and ptr; outputs a one-hot grant and an index; purely combinational.

Verification
REQ-034 The bench SHALL cover: after reset, ch_req[2]=1, ch_we[2]=1, addr 0x100, wdata 0xA5, busy=0 -> next cycle wr_req=1, addr=0x100, wdata=0xA5, ch_gnt=4'b0100.
REQ-035 The bench SHALL cover: read on ch1, rd_rdy with rdata=0x3C three cycles after rd_req -> one cycle later ch_rd_rdy=4'b0010, ch_rdata=0x3C.
REQ-036 The bench SHALL cover: all four channels requesting continuously with MEM_ARB_RR_EN -> grant order 0,1,2,3,0; without the macro -> 0,0,0.
REQ-037 The bench SHALL cover: busy=1 held in IDLE with requests pending -> no grant and no wr_req/rd_req until busy=0.
REQ-038 The bench SHALL cover: reset asserted in WAIT_RD, then rd_rdy=1 -> no ch_rd_rdy pulse, and the block is in IDLE with all outputs 0.
REQ-039 The bench SHALL cover: rd_rdy=1 during WAIT_WR -> no ch_rd_rdy pulse, and the write completes normally when busy=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter: FSM state encoding,
// default sizing constants and a pointer-width helper.
package mem_arb_pkg;

  localparam int NCH_DEF = 4;
  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    WAIT_RD = 2'd3
  } arb_state_t;

  // Width of a channel index; never less than one bit
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. The search starts at channel ptr and wraps
// around; with ptr held at 0 this is plain lowest-index-wins priority.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PW  = ptr_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx
);

  int   cand;
  logic found;

  // First requesting channel at or after ptr, modulo NCH
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (int'(ptr) + k) % NCH;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Multi-channel memory request arbiter: one transaction outstanding at a time,
// registered grant/request outputs, read data returned to the owning channel.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration; without it the
// lowest requesting index always wins and no pointer register exists.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_rd_rdy,
  output logic [DW-1:0]     ch_rdata,
  output logic [AW-1:0]     addr,
  output logic              wr_req,
  output logic              rd_req,
  output logic [DW-1:0]     wdata,
  input  logic [DW-1:0]     rdata,
  input  logic              busy,
  input  logic              rd_rdy
);

  localparam int PW = ptr_w(NCH);

  arb_state_t     state_q, state_d;
  logic [NCH-1:0] pick_gnt;
  logic [PW-1:0]  pick_idx;
  logic [PW-1:0]  ptr;
  logic           grant_fire;
  logic [AW-1:0]  sel_addr_p0;
  logic [DW-1:0]  sel_wdata_p0;
  logic           sel_we_p0;
  logic           we_p1;
  logic [NCH-1:0] own_p1;
  logic           wr_first_q;
  logic           rd_take;

  mem_arb_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req (ch_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // A new transaction starts only from IDLE with the memory not busy
  assign grant_fire = (state_q == IDLE) && (|ch_req) && !busy;
  // Read data is accepted only while a read is actually outstanding
  assign rd_take    = (state_q == WAIT_RD) && rd_rdy;

`ifdef MEM_ARB_RR_EN
  logic [PW-1:0] ptr_q;

  // Round-robin pointer moves to the slot after the winner on every grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_fire) begin
      ptr_q <= (pick_idx == PW'(NCH - 1)) ? '0 : pick_idx + PW'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // ---- stage p0: select the winning channel's request fields ----
  // Route the winner's address, write data and direction toward the latch
  always_comb begin
    sel_addr_p0  = '0;
    sel_wdata_p0 = '0;
    sel_we_p0    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (PW'(i) == pick_idx) begin
        sel_addr_p0  = ch_addr[i*AW +: AW];
        sel_wdata_p0 = ch_wdata[i*DW +: DW];
        sel_we_p0    = ch_we[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the write wait ignores busy on its first cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = ISSUE;
      ISSUE:   state_d = we_p1 ? WAIT_WR : WAIT_RD;
      WAIT_WR: if (!wr_first_q && !busy) state_d = IDLE;
      WAIT_RD: if (rd_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Marks the first WAIT_WR cycle so busy is not sampled there
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_first_q <= 1'b0;
    end else begin
      wr_first_q <= (state_q == ISSUE);
    end
  end

  // ---- stage p1: latched transaction, registered memory-side request ----
  // Grant and request strobes are single-cycle pulses during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_gnt <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      we_p1  <= 1'b0;
      own_p1 <= '0;
    end else begin
      ch_gnt <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      if (grant_fire) begin
        ch_gnt <= pick_gnt;
        wr_req <= sel_we_p0;
        rd_req <= !sel_we_p0;
        we_p1  <= sel_we_p0;
        own_p1 <= pick_gnt;
      end
    end
  end

  // Address and write data are captured at grant and held until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      wdata <= '0;
    end else if (grant_fire) begin
      addr  <= sel_addr_p0;
      wdata <= sel_wdata_p0;
    end
  end

  // ---- stage p2: read response back to the owning channel ----
  // Read data is registered and flagged to the owner for exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_rd_rdy <= '0;
      ch_rdata  <= '0;
    end else begin
      ch_rd_rdy <= '0;
      if (rd_take) begin
        ch_rd_rdy <= own_p1;
        ch_rdata  <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed, table-driven bench for mem_req_arbiter plus a continuous-request
// grant-order sequence whose expectation depends on MEM_ARB_RR_EN.
module tb_mem_req_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  ch_req;
  logic [3:0]  ch_we;
  logic [127:0] ch_addr;
  logic [31:0] ch_wdata;
  logic [3:0]  ch_gnt;
  logic [3:0]  ch_rd_rdy;
  logic [7:0]  ch_rdata;
  logic [31:0] addr;
  logic        wr_req;
  logic        rd_req;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        rd_rdy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_req_arbiter #(.NCH(4), .AW(32), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_gnt    (ch_gnt),
    .ch_rd_rdy (ch_rd_rdy),
    .ch_rdata  (ch_rdata),
    .addr      (addr),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .rd_rdy    (rd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic        bsy;
    logic        rrdy;
    logic [7:0]  rdat;
    logic [3:0]  e_gnt;
    logic        e_wr;
    logic        e_rd;
    logic [31:0] e_addr;
    logic [7:0]  e_wd;
    logic [3:0]  e_rrdy;
    logic [7:0]  e_rdo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] we, logic bsy,
                              logic rrdy, logic [7:0] rdat, logic [3:0] e_gnt,
                              logic e_wr, logic e_rd, logic [31:0] e_addr,
                              logic [7:0] e_wd, logic [3:0] e_rrdy, logic [7:0] e_rdo);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.bsy = bsy; v.rrdy = rrdy; v.rdat = rdat;
    v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_rd = e_rd; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_rrdy = e_rrdy; v.e_rdo = e_rdo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  logic [3:0] exp_order[5];
  logic [3:0] seen[5];
  int         n_exp;
  int         n_seen;

  initial begin
    // Channel i: address 0xC0 + 0x20*i (ch2 = 0x100), write data 0xA3 + i (ch2 = 0xA5)
    for (int i = 0; i < 4; i++) begin
      ch_addr[i*32 +: 32] = 32'(32'h0C0 + i * 32'h20);
      ch_wdata[i*8 +: 8]  = 8'(8'hA3 + i);
    end
    reset = 1'b1; ch_req = '0; ch_we = '0; busy = 1'b0; rd_rdy = 1'b0; rdata = '0;

    //            rst req    we     bsy rrdy rdat   gnt    wr rd  addr       wd     rrdy   rdo
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h000, 8'h00, 4'h0, 8'h00)); // reset
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h000, 8'h00, 4'h0, 8'h00)); // idle
    tbl.push_back(mk(0, 4'h4, 4'h4, 0, 0, 8'h00, 4'h4, 1, 0, 32'h100, 8'hA5, 4'h0, 8'h00)); // ch2 write
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h11, 4'h0, 0, 0, 32'h100, 8'hA5, 4'h0, 8'h00)); // ISSUE, rd_rdy ignored
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h22, 4'h0, 0, 0, 32'h100, 8'hA5, 4'h0, 8'h00)); // WAIT_WR 1st, ignored
    tbl.push_back(mk(0, 4'h2, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 32'h100, 8'hA5, 4'h0, 8'h00)); // WAIT_WR busy
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 1, 8'h33, 4'h0, 0, 0, 32'h100, 8'hA5, 4'h0, 8'h00)); // -> IDLE
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 8'h00, 4'h2, 0, 1, 32'h0E0, 8'hA4, 4'h0, 8'h00)); // ch1 read
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h77, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h00)); // ISSUE, ignored
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h00)); // WAIT_RD
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h00)); // WAIT_RD
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h3C, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h2, 8'h3C)); // read data
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h3C)); // pulse ends
    tbl.push_back(mk(0, 4'h3, 4'h3, 1, 0, 8'h00, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h3C)); // busy blocks
    tbl.push_back(mk(0, 4'h3, 4'h3, 1, 0, 8'h00, 4'h0, 0, 0, 32'h0E0, 8'hA4, 4'h0, 8'h3C)); // busy blocks
    tbl.push_back(mk(0, 4'h3, 4'h3, 0, 0, 8'h00, 4'h1, 1, 0, 32'h0C0, 8'hA3, 4'h0, 8'h3C)); // ch0 write
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0C0, 8'hA3, 4'h0, 8'h3C));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0C0, 8'hA3, 4'h0, 8'h3C));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h0C0, 8'hA3, 4'h0, 8'h3C));
    tbl.push_back(mk(0, 4'h4, 4'h0, 0, 0, 8'h00, 4'h4, 0, 1, 32'h100, 8'hA5, 4'h0, 8'h3C)); // ch2 read
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h100, 8'hA5, 4'h0, 8'h3C)); // -> WAIT_RD
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 1, 8'h55, 4'h0, 0, 0, 32'h000, 8'h00, 4'h0, 8'h00)); // reset wins
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h66, 4'h0, 0, 0, 32'h000, 8'h00, 4'h0, 8'h00)); // stale rd_rdy
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 32'h000, 8'h00, 4'h0, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst;
      ch_req = tbl[i].req;
      ch_we  = tbl[i].we;
      busy   = tbl[i].bsy;
      rd_rdy = tbl[i].rrdy;
      rdata  = tbl[i].rdat;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ch_gnt", i),    64'(ch_gnt),    64'(tbl[i].e_gnt));
      chk($sformatf("v%0d wr_req", i),    64'(wr_req),    64'(tbl[i].e_wr));
      chk($sformatf("v%0d rd_req", i),    64'(rd_req),    64'(tbl[i].e_rd));
      chk($sformatf("v%0d addr", i),      64'(addr),      64'(tbl[i].e_addr));
      chk($sformatf("v%0d wdata", i),     64'(wdata),     64'(tbl[i].e_wd));
      chk($sformatf("v%0d ch_rd_rdy", i), 64'(ch_rd_rdy), 64'(tbl[i].e_rrdy));
      chk($sformatf("v%0d ch_rdata", i),  64'(ch_rdata),  64'(tbl[i].e_rdo));
    end

    // Continuous requests from all channels, writes, memory never busy
`ifdef MEM_ARB_RR_EN
    n_exp = 5;
    exp_order[0] = 4'h1; exp_order[1] = 4'h2; exp_order[2] = 4'h4;
    exp_order[3] = 4'h8; exp_order[4] = 4'h1;
`else
    n_exp = 3;
    exp_order[0] = 4'h1; exp_order[1] = 4'h1; exp_order[2] = 4'h1;
    exp_order[3] = 4'h0; exp_order[4] = 4'h0;
`endif
    reset = 1'b1; ch_req = '0; ch_we = '0; busy = 1'b0; rd_rdy = 1'b0; rdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b0; ch_req = 4'hF; ch_we = 4'hF;
    n_seen = 0;
    for (int c = 0; c < 60 && n_seen < n_exp; c++) begin
      @(posedge clk);
      #1;
      if (ch_gnt != 4'h0) begin
        seen[n_seen] = ch_gnt;
        n_seen++;
      end
    end
    ch_req = '0; ch_we = '0;
    chk("order grant count", 64'(n_seen), 64'(n_exp));
    for (int g = 0; g < n_exp; g++) begin
      if (g < n_seen) begin
        chk($sformatf("order grant %0d", g), 64'(seen[g]), 64'(exp_order[g]));
      end else begin
        chk($sformatf("order grant %0d missing", g), 64'(4'h0), 64'(exp_order[g]));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
